// File: rtl/snake_if.sv
// Bundle of the control, food and display signals that pass between the
// game-flow logic and the snake engine.
interface snake_if #(
  parameter int X_W     = 4,
  parameter int Y_W     = 4,
  parameter int MAX_LEN = 16
);
  logic                   step;
  logic                   gaming;
  logic                   score_zero;
  logic [2:0]             direction;
  logic [X_W-1:0]         food_x;
  logic [Y_W-1:0]         food_y;
  logic                   food_valid;

  logic [X_W-1:0]         head_x;
  logic [Y_W-1:0]         head_y;
  logic [MAX_LEN*X_W-1:0] body_x;
  logic [MAX_LEN*Y_W-1:0] body_y;
  logic [4:0]             length;
  logic [7:0]             score;
  logic                   gameover;
  logic                   food_eaten;
  logic                   alive;

  modport master (
    output step, gaming, score_zero, direction, food_x, food_y, food_valid,
    input  head_x, head_y, body_x, body_y, length, score, gameover,
           food_eaten, alive
  );

  modport slave (
    input  step, gaming, score_zero, direction, food_x, food_y, food_valid,
    output head_x, head_y, body_x, body_y, length, score, gameover,
           food_eaten, alive
  );
endinterface

// File: rtl/snake_engine.sv
// Snake movement engine: shifts body segments one cell per move tick,
// detects wall/self collisions and tracks food, length and score.
module snake_engine #(
  parameter int GRID_W   = 16,
  parameter int GRID_H   = 12,
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3
) (
  input logic    clk,
  input logic    rst,
  snake_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DEAD = 2'd2;

  localparam logic [2:0] DIR_UP   = 3'd0;
  localparam logic [2:0] DIR_DOWN = 3'd1;
  localparam logic [2:0] DIR_LEFT = 3'd2;

  localparam logic [4:0]     LEN_INIT = 5'(INIT_LEN);
  localparam logic [4:0]     LEN_MAX  = 5'(MAX_LEN);
  localparam logic [X_W-1:0] X_LAST   = X_W'(GRID_W - 1);
  localparam logic [Y_W-1:0] Y_LAST   = Y_W'(GRID_H - 1);

  logic [1:0]     state_reg;
  logic           alive_reg;
  logic [4:0]     length_reg;
  logic [7:0]     score_reg;
  logic           gameover_reg;
  logic           food_eaten_reg;

  logic           init;
  logic [X_W-1:0] head_x_reg;
  logic [Y_W-1:0] head_y_reg;
  logic [X_W-1:0] head_x_next;
  logic [Y_W-1:0] head_y_next;
  logic           wall;
  logic           eat;
  logic [4:0]     self_limit;
  logic [MAX_LEN-1:0] hit;
  logic           crash;
  logic           move_req;
  logic           move_commit;

  assign init = !rst || bus.score_zero;

  // Candidate head; out-of-range wraps here are harmless because wall wins.
  always_comb begin
    head_x_next = head_x_reg;
    head_y_next = head_y_reg;
    wall        = 1'b0;
    case (bus.direction)
      DIR_UP: begin
        head_y_next = head_y_reg - Y_W'(1);
        wall        = (head_y_reg == '0);
      end
      DIR_DOWN: begin
        head_y_next = head_y_reg + Y_W'(1);
        wall        = (head_y_reg == Y_LAST);
      end
      DIR_LEFT: begin
        head_x_next = head_x_reg - X_W'(1);
        wall        = (head_x_reg == '0);
      end
      default: begin
        head_x_next = head_x_reg + X_W'(1);
        wall        = (head_x_reg == X_LAST);
      end
    endcase
  end

  assign eat = bus.food_valid && (head_x_next == bus.food_x) &&
               (head_y_next == bus.food_y);

  // The tail cell is vacated by the move unless the snake grows this step.
  assign self_limit = (eat && (length_reg < LEN_MAX)) ? length_reg - 5'd1
                                                      : length_reg - 5'd2;

  assign move_req    = (state_reg == ST_RUN) && bus.step && bus.gaming;
  assign crash       = wall || (|hit);
  assign move_commit = move_req && !crash;

  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : slot
      localparam logic [X_W-1:0] INIT_X =
        (gi < INIT_LEN) ? X_W'(GRID_W / 2 - gi) : X_W'(0);
      localparam logic [Y_W-1:0] INIT_Y =
        (gi < INIT_LEN) ? Y_W'(GRID_H / 2) : Y_W'(0);

      logic [X_W-1:0] x_reg;
      logic [Y_W-1:0] y_reg;
      logic [X_W-1:0] x_shift;
      logic [Y_W-1:0] y_shift;

      if (gi == 0) begin : g_head
        assign x_shift = head_x_next;
        assign y_shift = head_y_next;
        assign hit[gi] = 1'b0;
      end else begin : g_body
        assign x_shift = slot[gi-1].x_reg;
        assign y_shift = slot[gi-1].y_reg;
        assign hit[gi] = (x_reg == head_x_next) && (y_reg == head_y_next) &&
                         (5'(gi) <= self_limit);
      end

      always_ff @(posedge clk) begin
        if (init) begin
          x_reg <= INIT_X;
          y_reg <= INIT_Y;
        end else if (move_commit) begin
          x_reg <= x_shift;
          y_reg <= y_shift;
        end
      end

      assign bus.body_x[gi*X_W +: X_W] = x_reg;
      assign bus.body_y[gi*Y_W +: Y_W] = y_reg;
    end
  endgenerate

  assign head_x_reg = slot[0].x_reg;
  assign head_y_reg = slot[0].y_reg;

  always_ff @(posedge clk) begin
    if (init) begin
      state_reg      <= ST_IDLE;
      alive_reg      <= 1'b0;
      length_reg     <= LEN_INIT;
      score_reg      <= 8'd0;
      gameover_reg   <= 1'b0;
      food_eaten_reg <= 1'b0;
    end else begin
      gameover_reg   <= 1'b0;
      food_eaten_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.gaming) begin
            state_reg <= ST_RUN;
            alive_reg <= 1'b1;
          end
        end
        ST_RUN: begin
          if (move_req) begin
            if (crash) begin
              gameover_reg <= 1'b1;
              state_reg    <= ST_DEAD;
              alive_reg    <= 1'b0;
            end else if (eat) begin
              food_eaten_reg <= 1'b1;
              if (score_reg != 8'hFF) score_reg <= score_reg + 8'd1;
              if (length_reg < LEN_MAX) length_reg <= length_reg + 5'd1;
            end
          end
        end
        default: begin
          // Frozen for display until re-initialised.
          state_reg <= ST_DEAD;
          alive_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.head_x     = head_x_reg;
  assign bus.head_y     = head_y_reg;
  assign bus.length     = length_reg;
  assign bus.score      = score_reg;
  assign bus.gameover   = gameover_reg;
  assign bus.food_eaten = food_eaten_reg;
  assign bus.alive      = alive_reg;

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine: directed scenarios plus randomized
// play, compared every cycle against a queue-based reference model.
module tb_snake_engine;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int ML = 16;
  localparam int IL = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  snake_if #(.X_W(4), .Y_W(4), .MAX_LEN(ML)) bus ();

  snake_engine #(
    .GRID_W(GW), .GRID_H(GH), .X_W(4), .Y_W(4), .MAX_LEN(ML), .INIT_LEN(IL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: queue of all slots, head first.
  int qx[$];
  int qy[$];
  int m_len, m_score, m_state;  // state: 0 idle, 1 run, 2 dead
  bit m_go, m_eat;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_init();
    qx.delete();
    qy.delete();
    for (int i = 0; i < ML; i++) begin
      qx.push_back(i < IL ? GW / 2 - i : 0);
      qy.push_back(i < IL ? GH / 2 : 0);
    end
    m_len = IL; m_score = 0; m_state = 0; m_go = 0; m_eat = 0;
  endfunction

  function automatic void next_cell(int dir, output int nx, output int ny);
    nx = qx[0];
    ny = qy[0];
    case (dir)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx - 1;
      default: nx = nx + 1;
    endcase
  endfunction

  function automatic void model_clock(bit r, bit sz, bit st, bit g, int dir,
                                      int fx, int fy, bit fv);
    int nx, ny, lim;
    bit wall, eat, hit;
    m_go = 0;
    m_eat = 0;
    if (!r || sz) begin
      model_init();
    end else if (m_state == 0) begin
      if (g) m_state = 1;
    end else if (m_state == 1 && st && g) begin
      next_cell(dir, nx, ny);
      wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
      eat  = fv && (nx == fx) && (ny == fy);
      lim  = (eat && m_len < ML) ? m_len - 1 : m_len - 2;
      hit  = 0;
      for (int i = 1; i <= lim; i++)
        if (qx[i] == nx && qy[i] == ny) hit = 1;
      if (wall || hit) begin
        m_go = 1;
        m_state = 2;
      end else begin
        qx.push_front(nx);
        qy.push_front(ny);
        void'(qx.pop_back());
        void'(qy.pop_back());
        if (eat) begin
          m_eat = 1;
          if (m_score < 255) m_score++;
          if (m_len < ML) m_len++;
        end
      end
    end
  endfunction

  task automatic compare_all(string tag);
    logic [63:0] ebx, eby;
    ebx = '0;
    eby = '0;
    for (int i = 0; i < ML; i++) begin
      ebx[i*4 +: 4] = 4'(qx[i]);
      eby[i*4 +: 4] = 4'(qy[i]);
    end
    check({tag, ".head_x"}, 64'(bus.head_x), 64'(qx[0]));
    check({tag, ".head_y"}, 64'(bus.head_y), 64'(qy[0]));
    check({tag, ".body_x"}, bus.body_x, ebx);
    check({tag, ".body_y"}, bus.body_y, eby);
    check({tag, ".length"}, 64'(bus.length), 64'(m_len));
    check({tag, ".score"}, 64'(bus.score), 64'(m_score));
    check({tag, ".gameover"}, 64'(bus.gameover), 64'(m_go));
    check({tag, ".food_eaten"}, 64'(bus.food_eaten), 64'(m_eat));
    check({tag, ".alive"}, 64'(bus.alive), 64'(m_state == 1));
  endtask

  task automatic cycle(string tag, bit r, bit sz, bit st, bit g, int dir,
                       int fx, int fy, bit fv);
    rst            = r;
    bus.score_zero = sz;
    bus.step       = st;
    bus.gaming     = g;
    bus.direction  = 3'(dir);
    bus.food_x     = 4'(fx);
    bus.food_y     = 4'(fy);
    bus.food_valid = fv;
    model_clock(r, sz, st, g, dir, fx, fy, fv);
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  // Clockwise walk around the border; interior cells head upward first.
  function automatic int ring_dir(int x, int y);
    if (x == 0 && y > 0) return 0;
    if (y == 0 && x < GW - 1) return 3;
    if (x == GW - 1 && y < GH - 1) return 1;
    if (y == GH - 1 && x > 0) return 2;
    return 0;
  endfunction

  initial begin
    int nx, ny, dir, extra;

    // Reset
    cycle("rst0", 0, 0, 0, 0, 3, 0, 0, 0);
    cycle("rst1", 0, 0, 1, 1, 3, 0, 0, 0);
    check("rst.head_x_const", 64'(bus.head_x), 64'd8);
    check("rst.seg2_x_const", 64'(bus.body_x[11:8]), 64'd6);

    // IDLE -> RUN; a step in that cycle is ignored
    cycle("idle_step", 1, 0, 1, 1, 3, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle("right3", 1, 0, 1, 1, 3, 0, 0, 0);
    check("right3.head_x_const", 64'(bus.head_x), 64'd11);
    check("right3.seg2_x_const", 64'(bus.body_x[11:8]), 64'd9);

    // Eat while moving up
    cycle("init_eat", 1, 1, 0, 1, 0, 0, 0, 0);
    cycle("run_eat", 1, 0, 0, 1, 0, 0, 0, 0);
    cycle("eat_up", 1, 0, 1, 1, 0, 8, 5, 1);
    check("eat_up.length_const", 64'(bus.length), 64'd4);
    cycle("eat_after", 1, 0, 0, 1, 0, 8, 5, 1);

    // Wall collision on the right edge, then frozen while DEAD
    cycle("init_wall", 1, 1, 0, 1, 3, 0, 0, 0);
    cycle("run_wall", 1, 0, 0, 1, 3, 0, 0, 0);
    for (int i = 0; i < 7; i++) cycle("to_edge", 1, 0, 1, 1, 3, 0, 0, 0);
    check("to_edge.head_x_const", 64'(bus.head_x), 64'd15);
    cycle("wall_hit", 1, 0, 1, 1, 3, 0, 0, 0);
    check("wall_hit.gameover_const", 64'(bus.gameover), 64'd1);
    for (int i = 0; i < 5; i++) cycle("dead_step", 1, 0, 1, 1, 3, 0, 0, 0);
    cycle("dead_clear", 1, 1, 0, 0, 3, 0, 0, 0);

    // Reverse direction hits segment 1
    cycle("run_rev", 1, 0, 0, 1, 3, 0, 0, 0);
    cycle("rev_right", 1, 0, 1, 1, 3, 0, 0, 0);
    cycle("rev_left", 1, 0, 1, 1, 2, 0, 0, 0);
    check("rev_left.gameover_const", 64'(bus.gameover), 64'd1);

    // Grow to MAX_LEN and saturate score, looping around the border
    cycle("init_ring", 1, 1, 0, 1, 3, 0, 0, 0);
    cycle("run_ring", 1, 0, 0, 1, 3, 0, 0, 0);
    extra = 0;
    for (int k = 0; k < 3000 && extra < 4; k++) begin
      bit do_eat, do_step, g, fv;
      int fx, fy;
      dir = ring_dir(qx[0], qy[0]);
      next_cell(dir, nx, ny);
      do_eat  = ($urandom_range(0, 3) != 0);
      do_step = ($urandom_range(0, 7) != 0);
      g       = ($urandom_range(0, 15) != 0);
      fx      = do_eat ? nx : int'($urandom_range(0, GW - 1));
      fy      = do_eat ? ny : int'($urandom_range(0, GH - 1));
      fv      = do_eat ? 1'b1 : 1'($urandom_range(0, 1));
      cycle("ring", 1, 0, do_step, g, dir, fx, fy, fv);
      if (m_score == 255 && m_eat) extra++;
    end
    check("ring.length_const", 64'(bus.length), 64'd16);
    check("ring.score_const", 64'(bus.score), 64'd255);

    // score_zero and step together: init wins
    dir = ring_dir(qx[0], qy[0]);
    next_cell(dir, nx, ny);
    cycle("sz_step", 1, 1, 1, 1, dir, nx, ny, 1);
    check("sz_step.head_x_const", 64'(bus.head_x), 64'd8);

    // Random games until death
    for (int game = 0; game < 8; game++) begin
      cycle("rnd_init", 1, 1, 0, 1, 3, 0, 0, 0);
      for (int k = 0; k < 400 && m_state != 2; k++) begin
        int fx, fy;
        bit near;
        dir  = int'($urandom_range(0, 7));
        near = ($urandom_range(0, 1) != 0);
        next_cell(dir, nx, ny);
        fx = near ? nx : int'($urandom_range(0, GW - 1));
        fy = near ? ny : int'($urandom_range(0, GH - 1));
        cycle("rnd", 1, 0, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 7) != 0), dir, fx, fy,
              1'($urandom_range(0, 3) != 0));
      end
      cycle("rnd_dead", 1, 0, 1, 1, 3, 0, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
